// File: rtl/clint_irq_pkg.sv
// clint_irq_pkg: register map, cause codes and FSM states shared by the CLINT interrupt delivery stage.
package clint_irq_pkg;
  localparam int ADDR_PENDING = 'h00;
  localparam int ADDR_ENABLE = 'h04;
  localparam int ADDR_COUNT_BASE = 'h10;
  localparam int COUNT_W = 16;
  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;
  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;
  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    for (int i = 0; i < 4; i++) strb_mask[8*i+:8] = {8{s[i]}};
  endfunction
endpackage

// File: rtl/clint_irq_core.sv
// clint_irq_core: per-hart request/ack FSM, cause latch, pending-clear request and saturating delivery counter.
module clint_irq_core
  import clint_irq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         pend,
  input  logic [1:0]         en,
  input  logic               ack,
  input  logic               cnt_clr,
  output logic               req,
  output logic [3:0]         cause,
  output logic [1:0]         clr,
  output logic [COUNT_W-1:0] count
);
  state_t state, state_n;
  logic sel, sel_n;
  logic [1:0] elig;
  assign elig = pend & en;
  assign req = state == REQ;
  assign cause = req ? (sel ? CAUSE_MTI : CAUSE_MSI) : 4'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel <= 1'b0;
      count <= '0;
    end else begin
      state <= state_n;
      sel <= sel_n;
      count <= cnt_clr ? '0 : (state == REQ && ack && count != '1) ? count + 1'b1 : count;
    end
  end
  // sel: 0 = software (bit 0), 1 = timer (bit 1); software wins when both are eligible
  always_comb begin
    state_n = state;
    sel_n = sel;
    clr = '0;
    if (state == IDLE) begin
      state_n = |elig ? REQ : IDLE;
      sel_n = |elig ? ~elig[0] : sel;
    end else if (ack) begin
      state_n = IDLE;
      clr = sel ? 2'b10 : 2'b01;
    end else if (!elig[sel]) begin
      state_n = IDLE;
    end
  end
endmodule

// File: rtl/clint_irq_ctrl.sv
// clint_irq_ctrl: latches CLINT mtip/msip rising edges and delivers enabled interrupts per hart over a bus-programmed block.
module clint_irq_ctrl
  import clint_irq_pkg::*;
#(
  parameter int N_CORES = 1,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid,
  input  logic [ADDR_W-1:0]      address,
  input  logic [DATA_W-1:0]      wdata,
  input  logic [DATA_W/8-1:0]    wstrb,
  output logic [DATA_W-1:0]      rdata,
  output logic                   ready,
  input  logic [N_CORES-1:0]     mtip,
  input  logic [N_CORES-1:0]     msip,
  output logic [N_CORES-1:0]     irq_req,
  output logic [4*N_CORES-1:0]   irq_cause,
  input  logic [N_CORES-1:0]     irq_ack
);
  localparam int P = 2 * N_CORES;
  localparam logic [DATA_W-1:0] PMASK = DATA_W'((64'd1 << P) - 64'd1);
  logic [DATA_W-1:0] pend, en, mask, rd, w1c;
  logic [ADDR_W-1:0] off;
  logic [N_CORES-1:0] mtip_q, msip_q;
  logic [P-1:0] rise, core_clr;
  logic [COUNT_W-1:0] cnt [N_CORES];
  logic wr;
  assign wr = valid && |wstrb;
  assign off = address & ~ADDR_W'(3);
  assign mask = strb_mask(wstrb);
  assign w1c = wr && off == ADDR_W'(ADDR_PENDING) ? wdata & mask : '0;
  for (genvar g = 0; g < N_CORES; g++) begin : g_core
    assign rise[2*g] = msip[g] & ~msip_q[g];
    assign rise[2*g+1] = mtip[g] & ~mtip_q[g];
    clint_irq_core u_core (
      .clk(clk),
      .rst(reset),
      .pend(pend[2*g+:2]),
      .en(en[2*g+:2]),
      .ack(irq_ack[g]),
      .cnt_clr(wr && off == ADDR_W'(ADDR_COUNT_BASE + 4 * g)),
      .req(irq_req[g]),
      .cause(irq_cause[4*g+:4]),
      .clr(core_clr[2*g+:2]),
      .count(cnt[g])
    );
  end
  always_comb begin
    rd = off == ADDR_W'(ADDR_PENDING) ? pend : off == ADDR_W'(ADDR_ENABLE) ? en : '0;
    for (int k = 0; k < N_CORES; k++)
      rd = off == ADDR_W'(ADDR_COUNT_BASE + 4 * k) ? DATA_W'(cnt[k]) : rd;
  end
  // a new rising edge is OR-ed in last so it beats a same-cycle W1C or ack clear
  always_ff @(posedge clk) begin
    if (reset) begin
      mtip_q <= '0;
      msip_q <= '0;
      pend <= '0;
      en <= '0;
      ready <= 1'b0;
      rdata <= '0;
    end else begin
      mtip_q <= mtip;
      msip_q <= msip;
      ready <= valid;
      rdata <= valid && !wr ? rd : '0;
      pend <= (pend & ~w1c & ~DATA_W'(core_clr)) | DATA_W'(rise);
      en <= wr && off == ADDR_W'(ADDR_ENABLE) ? ((en & ~mask) | (wdata & mask)) & PMASK : en;
    end
  end
endmodule

// File: doc/clint_irq_ctrl.md
# clint_irq_ctrl

Per-hart interrupt delivery stage directly downstream of the CLINT. It consumes the CLINT's level `mtip`/`msip` vectors and latches their rising edges into pending bits. Enabled pending interrupts are presented to each core as a request/cause/acknowledge handshake. Software reaches the block through the same native valid/ready bus as the CLINT, for enable masks, write-1-to-clear pending bits and per-core delivery counters.

## Interface
Parameters:
- `N_CORES`, 1, number of harts; legal range 1..16.
- `ADDR_W`, 16, bus address width.
- `DATA_W`, 32, bus data width; fixed at 32.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `valid`  in  1  bus request strobe.
- `address`  in  ADDR_W  byte address; bits [1:0] ignored.
- `wdata`  in  DATA_W  write data.
- `wstrb`  in  DATA_W/8  byte write strobes; all-zero means read.
- `rdata`  out  DATA_W  read data, valid while `ready`=1.
- `ready`  out  1  one-cycle completion pulse.
- `mtip`  in  N_CORES  machine timer interrupt level from the CLINT.
- `msip`  in  N_CORES  machine software interrupt level from the CLINT.
- `irq_req`  out  N_CORES  per-core interrupt request.
- `irq_cause`  out  4*N_CORES  per-core cause code: 3 = software, 7 = timer. Stable while `irq_req` is high.
- `irq_ack`  in  N_CORES  per-core acknowledge.

## Operation
- Edge detect: `mtip_q`/`msip_q` are registered copies. A rising edge sets the pending bit: PEND[2k] for msip, PEND[2k+1] for mtip. Reset forces `*_q`=0, so a level already high at reset release is latched.
- Pending bits latch regardless of enable.
- Registers, word offsets:
  - 0x00 PENDING: read returns PEND; writing 1 clears the bit, byte strobes honoured.
  - 0x04 ENABLE: same bit layout; read/write with byte strobes; reset 0.
  - 0x10+4k COUNT_k: 16-bit saturating count of acknowledged deliveries, zero-extended on read; any write with nonzero strobe clears it.
  - Unmapped addresses: read 0, writes ignored, `ready` still pulses.
- Per-core FSM, states IDLE and REQ:
  - IDLE: if (PEND & ENABLE) for core k is nonzero, latch the cause and go to REQ. Software has priority over timer when both are eligible.
  - REQ: `irq_req`=1 with the latched cause. If `irq_ack`=1: clear that pending bit, increment COUNT_k (saturates at 0xFFFF), return to IDLE. Else, if the latched cause's pending&enable has dropped (W1C or disable): return to IDLE with no count.
  - `irq_ack` outside REQ is ignored.
- Simultaneous events:
  - W1C and a new rising edge on the same bit in one cycle: set wins.
  - Ack and withdrawal in one cycle: ack wins and counts.
  - COUNT write and ack in one cycle: write wins, result 0.

## Timing
- Reset values: `ready`=0, `rdata`=0, `irq_req`=0, `irq_cause`=0, PEND=0, ENABLE=0, COUNT=0, FSM=IDLE.
- Bus: `valid` is sampled at edge N. `ready`=1 and `rdata` are valid during cycle N+1 for exactly one cycle. The master issues no new `valid` until it has seen `ready`. A write takes effect at edge N.
- Interrupt latency: edge sampled at N → PEND set at N+1 → `irq_req` high from N+2. Two cycles from the first high sample to the request.
- Ack sampled at edge M: `irq_req` is low during cycle M+1, which is always one IDLE cycle. The next request can rise at M+2 at the earliest.
- Withdrawal: `irq_req` falls on the cycle after the drop is visible.
- Reset mid-REQ: `irq_req` drops the cycle after `reset` is sampled; no count.

## Structure
- Package `clint_irq_pkg`: register offsets (PENDING 0x00, ENABLE 0x04, COUNT_BASE 0x10), cause constants (CAUSE_MSI=3, CAUSE_MTI=7), FSM state enum, COUNT_W=16.
- Sub-module `clint_irq_core`: one per hart via generate. Contains the FSM, cause mux, saturating counter and the pending-clear request. The top owns the bus decode, PEND/ENABLE registers and edge detectors.

## Test plan
- Reset, then read PENDING/ENABLE/COUNT_0 → all 0; `ready` pulses exactly one cycle after each `valid`.
- ENABLE=0x3, pulse `mtip[0]` high → PEND=0x2; `irq_req[0]` high 2 cycles after the first high sample, cause 7; ack → req low next cycle, PEND=0, COUNT_0=1.
- `msip[0]` and `mtip[0]` rise together with ENABLE=0x3 → cause 3 first; after ack, one IDLE cycle, then cause 7.
- ENABLE=0, `mtip[0]` rises → PEND=0x2 and no request; write ENABLE=0x2 → request 1 cycle later; W1C PENDING=0x2 while in REQ → req drops, COUNT unchanged.
- W1C of bit 1 in the same cycle as a new `mtip[0]` rising edge → bit 1 remains set. Preload COUNT_0 at 0xFFFF, then ack → COUNT_0 stays 0xFFFF.
- `N_CORES`=2: interrupts on core 1 only → `irq_req`=2'b10, COUNT_1 increments, core 0 untouched. Assert `reset` mid-REQ → all outputs return to reset values.
